// File: rtl/pixel_gen_pkg.sv
// Shared definitions for the pixel generator: register word offsets,
// the ID constant, the RGB pixel type and the pack-phase state type.
package pixel_gen_pkg;

  // Number of 32-bit words that carry one group of four 24-bit pixels.
  localparam int PACK_PHASES = 3;

  // Register word offsets (byte address [7:2]).
  localparam logic [5:0] REG_PATTERN   = 6'h00;
  localparam logic [5:0] REG_BLUE      = 6'h01;
  localparam logic [5:0] REG_COLOUR    = 6'h02;
  localparam logic [5:0] REG_FRAME_CNT = 6'h03;
  localparam logic [5:0] REG_ID        = 6'h04;

  localparam logic [31:0] ID_VALUE = 32'h5049_5847;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Which word of the current pixel group is loaded next into the output register.
  typedef enum logic [1:0] {
    PH_WORD0 = 2'd0,
    PH_WORD1 = 2'd1,
    PH_WORD2 = 2'd2
  } pack_phase_e;

endpackage

// File: rtl/pixel_generator_if.sv
// Bus bundle for the pixel generator: the AXI4-Stream video output and the
// AXI4-Lite register port.
//   master : the pixel generator (stream source, register-bus target)
//   slave  : the environment (stream sink, register-bus host)
// Handshake rule for every channel: a beat moves on a rising clock edge where
// valid and ready are both 1; a source holding valid keeps its payload stable
// and does not drop valid until that edge.
interface pixel_generator_if #(
  parameter int ADDR_W = 8
);
  logic [31:0]       out_stream_tdata;
  logic [3:0]        out_stream_tkeep;
  logic              out_stream_tlast;
  logic              out_stream_tuser;
  logic              out_stream_tvalid;
  logic              out_stream_tready;

  logic [ADDR_W-1:0] s_axi_lite_awaddr;
  logic              s_axi_lite_awvalid;
  logic              s_axi_lite_awready;
  logic [31:0]       s_axi_lite_wdata;
  logic              s_axi_lite_wvalid;
  logic              s_axi_lite_wready;
  logic [1:0]        s_axi_lite_bresp;
  logic              s_axi_lite_bvalid;
  logic              s_axi_lite_bready;
  logic [ADDR_W-1:0] s_axi_lite_araddr;
  logic              s_axi_lite_arvalid;
  logic              s_axi_lite_arready;
  logic [31:0]       s_axi_lite_rdata;
  logic [1:0]        s_axi_lite_rresp;
  logic              s_axi_lite_rvalid;
  logic              s_axi_lite_rready;

  modport master (
    output out_stream_tdata, out_stream_tkeep, out_stream_tlast,
    output out_stream_tuser, out_stream_tvalid,
    input  out_stream_tready,
    input  s_axi_lite_awaddr, s_axi_lite_awvalid, output s_axi_lite_awready,
    input  s_axi_lite_wdata, s_axi_lite_wvalid, output s_axi_lite_wready,
    output s_axi_lite_bresp, s_axi_lite_bvalid, input s_axi_lite_bready,
    input  s_axi_lite_araddr, s_axi_lite_arvalid, output s_axi_lite_arready,
    output s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid,
    input  s_axi_lite_rready
  );

  modport slave (
    input  out_stream_tdata, out_stream_tkeep, out_stream_tlast,
    input  out_stream_tuser, out_stream_tvalid,
    output out_stream_tready,
    output s_axi_lite_awaddr, s_axi_lite_awvalid, input s_axi_lite_awready,
    output s_axi_lite_wdata, s_axi_lite_wvalid, input s_axi_lite_wready,
    input  s_axi_lite_bresp, s_axi_lite_bvalid, output s_axi_lite_bready,
    output s_axi_lite_araddr, s_axi_lite_arvalid, input s_axi_lite_arready,
    input  s_axi_lite_rdata, s_axi_lite_rresp, s_axi_lite_rvalid,
    output s_axi_lite_rready
  );
endinterface

// File: rtl/pixel_packer.sv
// Packs groups of four 24-bit pixels into three 32-bit stream words
// (LSB word first) behind a single registered output stage.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   pix_i             four pixels {p3,p2,p1,p0} of the group at the current x
//   sof_i, eol_i      group is first of frame / last of line
//   take_o            group consumed this cycle; the pixel counters advance
//   tdata_o..tready_i stream output
//   phase_o           current pack phase (debug)
module pixel_packer
  import pixel_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  rgb_t [3:0]  pix_i,
  input  logic        sof_i,
  input  logic        eol_i,
  output logic        take_o,
  output logic [31:0] tdata_o,
  output logic [3:0]  tkeep_o,
  output logic        tlast_o,
  output logic        tuser_o,
  output logic        tvalid_o,
  input  logic        tready_i,
  output pack_phase_e phase_o
);
  pack_phase_e phase_q, phase_d;
  logic [95:0] pix_flat;
  logic [63:0] grp_q, grp_d;   // upper two words of the group being emitted
  logic        eol_q, eol_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tlast_q, tlast_d, tuser_q, tuser_d, tvalid_q, tvalid_d;
  logic        load;

  assign pix_flat = pix_i;

  // The output register is refilled when it is empty or its word is leaving,
  // so tvalid never drops once the stream is running.
  assign load   = !tvalid_q || tready_i;
  assign take_o = load && (phase_q == PH_WORD0);

  always_comb begin
    phase_d  = phase_q;
    grp_d    = grp_q;
    eol_d    = eol_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    if (load) begin
      tvalid_d = 1'b1;
      case (phase_q)
        PH_WORD0: begin
          tdata_d = pix_flat[31:0];
          grp_d   = pix_flat[95:32];
          eol_d   = eol_i;
          tuser_d = sof_i;
          tlast_d = 1'b0;
          phase_d = PH_WORD1;
        end
        PH_WORD1: begin
          tdata_d = grp_q[31:0];
          tuser_d = 1'b0;
          tlast_d = 1'b0;
          phase_d = PH_WORD2;
        end
        PH_WORD2: begin
          tdata_d = grp_q[63:32];
          tuser_d = 1'b0;
          tlast_d = eol_q;
          phase_d = PH_WORD0;
        end
        default: phase_d = PH_WORD0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_WORD0;
      grp_q    <= '0;
      eol_q    <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      grp_q    <= grp_d;
      eol_q    <= eol_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign tdata_o  = tdata_q;
  assign tkeep_o  = 4'hF;
  assign tlast_o  = tlast_q;
  assign tuser_o  = tuser_q;
  assign tvalid_o = tvalid_q;
  assign phase_o  = phase_q;

endmodule

// File: rtl/pixel_generator.sv
// Synthetic RGB test-image source: AXI4-Stream video out (tuser = start of
// frame, tlast = end of line) configured by an AXI4-Lite register file.
// Ports:
//   out_stream_aclk / s_axi_lite_aclk  the same clock, stream and register side
//   axi_resetn                         async active-low reset, register file
//   periph_resetn                      async active-low reset, pixel/stream path
//   bus                                stream output + AXI4-Lite target
//   dbg_phase_o                        pack phase of the stream packer
module pixel_generator
  import pixel_gen_pkg::*;
#(
  parameter int X_SIZE     = 640,
  parameter int Y_SIZE     = 640,
  parameter int AXI_ADDR_W = 8
) (
  input  logic              out_stream_aclk,
  input  logic              s_axi_lite_aclk,
  input  logic              axi_resetn,
  input  logic              periph_resetn,
  pixel_generator_if.master bus,
  output pack_phase_e       dbg_phase_o
);
  localparam int          WA         = AXI_ADDR_W - 2;
  localparam logic [15:0] X_LAST_GRP = 16'(X_SIZE - 4);
  localparam logic [15:0] Y_LAST     = 16'(Y_SIZE - 1);

  // ---------------- register file ----------------
  logic          pattern_q;
  logic [7:0]    blue_q;
  logic [23:0]   colour_q;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic          awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]   rdata_q, rd_mux;
  logic [WA-1:0] wr_word, rd_word;
  logic          wr_fire, rd_fire;
  logic          unused_bits;

  assign wr_word = bus.s_axi_lite_awaddr[AXI_ADDR_W-1:2];
  assign rd_word = bus.s_axi_lite_araddr[AXI_ADDR_W-1:2];
  assign wr_fire = awready_q && bus.s_axi_lite_awvalid && bus.s_axi_lite_wvalid;
  assign rd_fire = arready_q && bus.s_axi_lite_arvalid;
  assign unused_bits = ^{bus.s_axi_lite_awaddr[1:0], bus.s_axi_lite_araddr[1:0],
                         bus.s_axi_lite_wdata[31:24]};

  always_comb begin
    rd_mux = '0;
    case (rd_word)
      WA'(REG_PATTERN):   rd_mux = {31'd0, pattern_q};
      WA'(REG_BLUE):      rd_mux = {24'd0, blue_q};
      WA'(REG_COLOUR):    rd_mux = {8'd0, colour_q};
      WA'(REG_FRAME_CNT): rd_mux = frame_cnt_q;
      WA'(REG_ID):        rd_mux = ID_VALUE;
      default:            rd_mux = '0;
    endcase
  end

  // awready/wready pulse together for one cycle; the write commits on the
  // following edge, and no new write is offered while a response is pending.
  always_ff @(posedge s_axi_lite_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pattern_q <= 1'b0;
      blue_q    <= '0;
      colour_q  <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= bus.s_axi_lite_awvalid && bus.s_axi_lite_wvalid && !bvalid_q && !awready_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        case (wr_word)
          WA'(REG_PATTERN): pattern_q <= bus.s_axi_lite_wdata[0];
          WA'(REG_BLUE):    blue_q    <= bus.s_axi_lite_wdata[7:0];
          WA'(REG_COLOUR):  colour_q  <= bus.s_axi_lite_wdata[23:0];
          default: ;
        endcase
      end else if (bvalid_q && bus.s_axi_lite_bready) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= bus.s_axi_lite_arvalid && !rvalid_q && !arready_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (rvalid_q && bus.s_axi_lite_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign bus.s_axi_lite_awready = awready_q;
  assign bus.s_axi_lite_wready  = awready_q;
  assign bus.s_axi_lite_bvalid  = bvalid_q;
  assign bus.s_axi_lite_bresp   = 2'b00;
  assign bus.s_axi_lite_arready = arready_q;
  assign bus.s_axi_lite_rvalid  = rvalid_q;
  assign bus.s_axi_lite_rdata   = rdata_q;
  assign bus.s_axi_lite_rresp   = 2'b00;

  // ---------------- pixel path ----------------
  logic [15:0] x_q, x_d, y_q, y_d;   // x is the first pixel of the current group
  rgb_t [3:0]  pix;
  logic        take;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pix[i] = rgb_t'(colour_q);
      if (!pattern_q) begin
        pix[i].r = x_q[7:0] + 8'(i);
        pix[i].g = y_q[7:0];
        pix[i].b = blue_q;
      end
    end
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    if (take) begin
      if (x_q == X_LAST_GRP) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d         = '0;
          frame_cnt_d = frame_cnt_q + 32'd1;
        end else begin
          y_d = y_q + 16'd1;
        end
      end else begin
        x_d = x_q + 16'd4;
      end
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  pixel_packer u_packer (
    .clk      (out_stream_aclk),
    .rst_n    (periph_resetn),
    .pix_i    (pix),
    .sof_i    ((x_q == 16'd0) && (y_q == 16'd0)),
    .eol_i    (x_q == X_LAST_GRP),
    .take_o   (take),
    .tdata_o  (bus.out_stream_tdata),
    .tkeep_o  (bus.out_stream_tkeep),
    .tlast_o  (bus.out_stream_tlast),
    .tuser_o  (bus.out_stream_tuser),
    .tvalid_o (bus.out_stream_tvalid),
    .tready_i (bus.out_stream_tready),
    .phase_o  (dbg_phase_o)
  );

endmodule

// File: tb/tb_pixel_generator.sv
// Bench for pixel_generator with a reduced 8x4 image so whole frames fit
// in a short run.
module tb_pixel_generator;
  import pixel_gen_pkg::*;

  localparam int X_SIZE     = 8;
  localparam int Y_SIZE     = 4;
  localparam int AXI_ADDR_W = 8;
  localparam int WPL        = X_SIZE * 3 / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic axi_resetn = 1'b0;
  logic periph_resetn = 1'b0;
  pack_phase_e dbg_phase;

  always #5 clk = ~clk;

  pixel_generator_if #(.ADDR_W(AXI_ADDR_W)) bus ();

  pixel_generator #(
    .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .AXI_ADDR_W(AXI_ADDR_W)
  ) dut (
    .out_stream_aclk (clk),
    .s_axi_lite_aclk (clk),
    .axi_resetn      (axi_resetn),
    .periph_resetn   (periph_resetn),
    .bus             (bus),
    .dbg_phase_o     (dbg_phase)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- stream model / monitor ----------------
  int          m_x = 0, m_y = 0, m_ph = 0;
  logic        m_pattern = 1'b0;
  logic [7:0]  m_blue = 8'h00;
  logic [23:0] m_colour = 24'h0;
  logic        chk_data = 1'b1;
  int          n_lines = 0, n_sof = 0, line_words = 0;
  logic        holding = 1'b0, seen_valid = 1'b0;
  logic [31:0] held_data;
  logic        held_last, held_user;

  function automatic logic [31:0] exp_word(int gx, int gy, int ph, logic pat,
                                           logic [7:0] blue, logic [23:0] col);
    logic [95:0] g;
    logic [23:0] p;
    g = '0;
    for (int i = 0; i < 4; i++) begin
      if (pat) p = col;
      else     p = {8'(gx + i), 8'(gy), blue};
      g[i*24 +: 24] = p;
    end
    return g[ph*32 +: 32];
  endfunction

  always @(negedge clk) begin
    if (!periph_resetn) begin
      m_x = 0; m_y = 0; m_ph = 0;
      holding = 1'b0; seen_valid = 1'b0; line_words = 0;
    end else begin
      if (seen_valid) check("tvalid_continuous", bus.out_stream_tvalid, 1);
      if (holding) begin
        check("hold_tdata", bus.out_stream_tdata, held_data);
        check("hold_tlast", bus.out_stream_tlast, held_last);
        check("hold_tuser", bus.out_stream_tuser, held_user);
      end
      holding = 1'b0;
      if (bus.out_stream_tvalid) begin
        seen_valid = 1'b1;
        if (bus.out_stream_tready) begin
          if (chk_data)
            check("tdata", bus.out_stream_tdata,
                  exp_word(m_x, m_y, m_ph, m_pattern, m_blue, m_colour));
          check("tuser", bus.out_stream_tuser, (m_x == 0 && m_y == 0 && m_ph == 0));
          check("tlast", bus.out_stream_tlast, (m_ph == 2 && m_x == X_SIZE - 4));
          line_words++;
          if (bus.out_stream_tuser) n_sof++;
          if (bus.out_stream_tlast) begin
            check("words_per_line", line_words, WPL);
            line_words = 0;
            n_lines++;
          end
          if (m_ph == 2) begin
            m_ph = 0;
            if (m_x == X_SIZE - 4) begin
              m_x = 0;
              m_y = (m_y == Y_SIZE - 1) ? 0 : m_y + 1;
            end else begin
              m_x = m_x + 4;
            end
          end else begin
            m_ph = m_ph + 1;
          end
        end else begin
          holding   = 1'b1;
          held_data = bus.out_stream_tdata;
          held_last = bus.out_stream_tlast;
          held_user = bus.out_stream_tuser;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input int hold);
    int cyc;
    @(posedge clk); #1;
    bus.s_axi_lite_awaddr = addr;  bus.s_axi_lite_awvalid = 1'b1;
    bus.s_axi_lite_wdata  = data;  bus.s_axi_lite_wvalid  = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.s_axi_lite_awready && cyc < 50);
    check("aw_w_ready", {bus.s_axi_lite_awready, bus.s_axi_lite_wready}, 2'b11);
    @(posedge clk); #1;
    bus.s_axi_lite_awvalid = 1'b0; bus.s_axi_lite_wvalid = 1'b0;
    if (hold > 0) begin
      // A second write offered while the response is still pending.
      bus.s_axi_lite_awaddr = 8'h04; bus.s_axi_lite_wdata = 32'h0000_0077;
      bus.s_axi_lite_awvalid = 1'b1; bus.s_axi_lite_wvalid = 1'b1;
    end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.s_axi_lite_bvalid && cyc < 50);
    check("bvalid", bus.s_axi_lite_bvalid, 1);
    check("bresp", bus.s_axi_lite_bresp, 2'b00);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_held", bus.s_axi_lite_bvalid, 1);
      check("no_second_aw", bus.s_axi_lite_awready, 0);
    end
    bus.s_axi_lite_awvalid = 1'b0; bus.s_axi_lite_wvalid = 1'b0;
    bus.s_axi_lite_bready = 1'b1;
    @(posedge clk); #1;
    bus.s_axi_lite_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    @(posedge clk); #1;
    bus.s_axi_lite_araddr = addr; bus.s_axi_lite_arvalid = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.s_axi_lite_arready && cyc < 50);
    check("arready", bus.s_axi_lite_arready, 1);
    @(posedge clk); #1;
    bus.s_axi_lite_arvalid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.s_axi_lite_rvalid && cyc < 50);
    check("rvalid", bus.s_axi_lite_rvalid, 1);
    data = bus.s_axi_lite_rdata;
    resp = bus.s_axi_lite_rresp;
    bus.s_axi_lite_rready = 1'b1;
    @(posedge clk); #1;
    bus.s_axi_lite_rready = 1'b0;
  endtask

  task automatic wait_lines(input int n);
    int target, cyc;
    target = n_lines + n;
    cyc = 0;
    while (n_lines < target && cyc < 2000) begin @(posedge clk); cyc++; end
    check("wait_lines_timeout", (n_lines >= target), 1);
  endtask

  task automatic wait_tlast_xfer();
    int cyc;
    cyc = 0;
    do begin @(negedge clk); cyc++; end
    while (!(bus.out_stream_tvalid && bus.out_stream_tready && bus.out_stream_tlast) && cyc < 200);
    check("tlast_seen", bus.out_stream_tlast, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] rd;
    logic [1:0]  rs;
    int cyc;
    bus.out_stream_tready  = 1'b1;
    bus.s_axi_lite_awaddr  = '0; bus.s_axi_lite_awvalid = 1'b0;
    bus.s_axi_lite_wdata   = '0; bus.s_axi_lite_wvalid  = 1'b0;
    bus.s_axi_lite_bready  = 1'b0;
    bus.s_axi_lite_araddr  = '0; bus.s_axi_lite_arvalid = 1'b0;
    bus.s_axi_lite_rready  = 1'b0;

    // Reset state.
    #22;
    check("rst_tvalid", bus.out_stream_tvalid, 0);
    check("rst_tdata", bus.out_stream_tdata, 32'h0);
    check("rst_tlast", bus.out_stream_tlast, 0);
    check("rst_tuser", bus.out_stream_tuser, 0);
    check("tkeep", bus.out_stream_tkeep, 4'hF);
    check("rst_phase", dbg_phase, PH_WORD0);
    check("rst_lite_ready_valid", {bus.s_axi_lite_awready, bus.s_axi_lite_wready,
          bus.s_axi_lite_bvalid, bus.s_axi_lite_arready, bus.s_axi_lite_rvalid}, 5'b0);

    @(posedge clk); #1;
    axi_resetn = 1'b1; periph_resetn = 1'b1;

    // tvalid within 4 cycles, then first group of frame 0 (pattern 0, blue 0).
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.out_stream_tvalid && cyc < 4);
    check("tvalid_rise", bus.out_stream_tvalid, 1);
    check("first_tuser", bus.out_stream_tuser, 1);
    check("word0", bus.out_stream_tdata, 32'h0000_0000);
    @(negedge clk);
    check("word1", bus.out_stream_tdata, 32'h0000_0100);
    check("word1_tuser", bus.out_stream_tuser, 0);
    @(negedge clk);
    check("word2", bus.out_stream_tdata, 32'h0300_0002);

    // Frame counter after two complete frames.
    cyc = 0;
    while (n_sof < 3 && cyc < 500) begin @(posedge clk); cyc++; end
    check("third_sof_seen", (n_sof >= 3), 1);
    axi_read(8'h0C, rd, rs);
    check("frame_cnt", rd, 32'd2);

    axi_read(8'h10, rd, rs);
    check("id", rd, 32'h5049_5847);
    check("id_rresp", rs, 2'b00);

    // BLUE write / readback; stream follows after the next lines.
    chk_data = 1'b0;
    axi_write(8'h04, 32'hFFFF_FFA5, 0);
    axi_read(8'h04, rd, rs);
    check("blue_rb", rd, 32'h0000_00A5);
    m_blue = 8'hA5;
    wait_lines(2);
    chk_data = 1'b1;

    // Random backpressure.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      bus.out_stream_tready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    bus.out_stream_tready = 1'b1;

    // Constant colour.
    chk_data = 1'b0;
    axi_write(8'h08, 32'h0011_2233, 0);
    axi_write(8'h00, 32'h0000_0001, 0);
    m_colour = 24'h112233; m_pattern = 1'b1;
    wait_lines(2);
    chk_data = 1'b1;
    wait_tlast_xfer();
    @(negedge clk); check("colour_w0", bus.out_stream_tdata, 32'h3311_2233);
    @(negedge clk); check("colour_w1", bus.out_stream_tdata, 32'h2233_1122);
    @(negedge clk); check("colour_w2", bus.out_stream_tdata, 32'h1122_3311);

    // Pending response blocks a second write.
    axi_write(8'h00, 32'h0000_0001, 10);
    axi_read(8'h04, rd, rs);
    check("blue_unchanged", rd, 32'h0000_00A5);

    // Unmapped address and unused bits.
    axi_write(8'h14, 32'hDEAD_BEEF, 0);
    axi_read(8'h14, rd, rs);
    check("unmapped_rd", rd, 32'h0);
    axi_read(8'h00, rd, rs);
    check("pattern_rb", rd, 32'h1);
    axi_read(8'h08, rd, rs);
    check("colour_rb", rd, 32'h0011_2233);

    // Peripheral reset mid-line.
    wait_tlast_xfer();
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    periph_resetn = 1'b0;
    #1;
    check("prst_tvalid", bus.out_stream_tvalid, 0);
    check("prst_tdata", bus.out_stream_tdata, 32'h0);
    check("prst_flags", {bus.out_stream_tlast, bus.out_stream_tuser}, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    periph_resetn = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end
    while (!(bus.out_stream_tvalid && bus.out_stream_tready) && cyc < 6);
    check("restart_tuser", bus.out_stream_tuser, 1);
    check("restart_word0", bus.out_stream_tdata, 32'h3311_2233);
    repeat (60) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
